// File: rtl/spi_ram_bridge_if.sv
// SPI pin bundle for spi_ram_bridge: the external master drives SS_n and MOSI,
// and the bridge drives MISO.
interface spi_ram_bridge_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output MOSI, input MISO);
  modport slave  (input SS_n, input MOSI, output MISO);
endinterface

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI-slave command engine in front of a single-port RAM with separate
// auto-incrementing write/read pointers. Define SPI_RAM_BURST_EN for multi-word streaming.
module spi_ram_bridge #(
  parameter int MEMDEPTH = 256,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_bridge_if.slave spi
);

  localparam int PTR_W = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
  localparam int IN_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(MEMDEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(MEMDEPTH - 1);
  localparam logic [CNT_W-1:0]   ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   DATA_END   = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CMD, LD_WADDR, LD_RADDR, WR_DATA, RD_TURN, RD_DATA, HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-2:0]   sh_q;
  logic [IN_W-1:0]   sh_next;
  logic              cmd_hi_q;
  logic              armed_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q, wptr_inc, rptr_inc;
  logic [DATA_W-1:0] rd_sh_q;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_val;
  logic              addr_ok;
  logic [PTR_W-1:0]  ram_addr;
  logic [DATA_W-1:0] mem [MEMDEPTH];

  logic cmd_load, shift_en, waddr_done, raddr_done, wr_done;
  logic rd_fetch, rd_shift, rd_word_done, rd_reload;

  assign sh_next  = {sh_q, spi.MOSI};
  assign addr_val = sh_next[ADDR_W-1:0];
  assign addr_ok  = {1'b0, addr_val} < ADDR_LIMIT;
  assign wptr_inc = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
  assign rptr_inc = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
  assign spi.MISO = miso_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miso_d       = 1'b0;
    cmd_load     = 1'b0;
    shift_en     = 1'b0;
    waddr_done   = 1'b0;
    raddr_done   = 1'b0;
    wr_done      = 1'b0;
    rd_fetch     = 1'b0;
    rd_shift     = 1'b0;
    rd_word_done = 1'b0;
    rd_reload    = 1'b0;
    if (spi.SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d  = CMD;
            cmd_load = 1'b1;
          end
        end
        CMD: begin
          cnt_d = '0;
          unique case (cmd_t'({cmd_hi_q, spi.MOSI}))
            CMD_WR_ADDR: state_d = LD_WADDR;
            CMD_WR_DATA: state_d = WR_DATA;
            CMD_RD_ADDR: state_d = LD_RADDR;
            CMD_RD_DATA: state_d = RD_TURN;
          endcase
        end
        LD_WADDR, LD_RADDR: begin
          shift_en = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            waddr_done = (state_q == LD_WADDR);
            raddr_done = (state_q == LD_RADDR);
            state_d    = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WR_DATA: begin
          shift_en = 1'b1;
          if (cnt_q == DATA_LAST) begin
            wr_done = 1'b1;
            cnt_d   = '0;
`ifdef SPI_RAM_BURST_EN
            state_d = WR_DATA;
`else
            state_d = HOLD;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RD_TURN: begin
          rd_fetch = 1'b1;
          state_d  = RD_DATA;
          cnt_d    = '0;
        end
        RD_DATA: begin
          // Count runs one past the last bit so MISO drops to 0 before HOLD.
          if (cnt_q != DATA_END) begin
            rd_shift = 1'b1;
            miso_d   = rd_sh_q[DATA_W-1];
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == DATA_LAST) begin
              rd_word_done = 1'b1;
`ifdef SPI_RAM_BURST_EN
              rd_reload = 1'b1;
              cnt_d     = '0;
`endif
            end
          end else begin
            state_d = HOLD;
          end
        end
        HOLD: state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Single RAM address bus: write pointer while writing, read pointer (or its successor
  // when prefetching the next burst word) otherwise.
  always_comb begin
    ram_addr = rptr_q;
    if (wr_done) ram_addr = wptr_q;
`ifdef SPI_RAM_BURST_EN
    else if (rd_reload) ram_addr = rptr_inc;
`endif
  end

  // NOTE: the RAM array has no reset so it maps onto plain RAM macros; its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_done) mem[ram_addr] <= sh_next[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sh_q     <= '0;
      cmd_hi_q <= 1'b0;
      armed_q  <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rd_sh_q  <= '0;
      miso_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
      // A frame is only accepted once SS_n has been seen high since reset.
      if (spi.SS_n) armed_q <= 1'b1;
      if (cmd_load) cmd_hi_q <= spi.MOSI;
      if (spi.SS_n)     sh_q <= '0;
      else if (shift_en) sh_q <= sh_next[IN_W-2:0];
      if (waddr_done && addr_ok) wptr_q <= addr_val[PTR_W-1:0];
      else if (wr_done)          wptr_q <= wptr_inc;
      if (raddr_done && addr_ok) rptr_q <= addr_val[PTR_W-1:0];
      else if (rd_word_done)     rptr_q <= rptr_inc;
      if (rd_fetch || rd_reload) rd_sh_q <= mem[ram_addr];
      else if (rd_shift)         rd_sh_q <= {rd_sh_q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Self-checking bench for spi_ram_bridge: a 256-word and a 200-word instance share the
// SPI stimulus; every sampled MISO bit is compared against a scoreboard of expected bits.
module tb_spi_ram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, ss_n, mosi, sel, miso;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  spi_ram_bridge_if ifa ();
  spi_ram_bridge_if ifb ();

  assign ifa.SS_n = sel ? 1'b1 : ss_n;
  assign ifa.MOSI = mosi;
  assign ifb.SS_n = sel ? ss_n : 1'b1;
  assign ifb.MOSI = mosi;
  assign miso     = sel ? ifb.MISO : ifa.MISO;

  spi_ram_bridge #(.MEMDEPTH(256), .DATA_W(8), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .spi(ifa)
  );
  spi_ram_bridge #(.MEMDEPTH(200), .DATA_W(8), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .spi(ifb)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_zeros(input int n);
    repeat (n) exp_q.push_back(1'b0);
  endtask

  // One serial bit: drive on the falling edge, compare MISO just after the rising edge.
  task automatic bit_cycle(input logic b, input string tag);
    logic e;
    @(negedge clk);
    ss_n = 1'b0;
    mosi = b;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, miso=%b", tag, miso);
    end else begin
      e = exp_q.pop_front();
      check(tag, {7'b0, miso}, {7'b0, e});
    end
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {7'b0, miso}, 8'h00);
  endtask

  task automatic cmd_word(input logic [1:0] cmd, input logic [7:0] v, input string tag);
    push_zeros(10);
    bit_cycle(cmd[1], tag);
    bit_cycle(cmd[0], tag);
    for (int i = 7; i >= 0; i--) bit_cycle(v[i], tag);
    end_frame(tag);
  endtask

  task automatic wr_addr(input logic [7:0] a);
    cmd_word(2'b00, a, "wr_addr");
  endtask

  task automatic rd_addr(input logic [7:0] a);
    cmd_word(2'b10, a, "rd_addr");
  endtask

  // Up to three words, MSB word first, in one WR_DATA frame.
  task automatic wr_data(input logic [23:0] w, input int nw, input string tag);
    logic [7:0] cur;
    push_zeros(2 + 8 * nw);
    bit_cycle(1'b0, tag);
    bit_cycle(1'b1, tag);
    for (int k = 0; k < nw; k++) begin
      cur = w[23 - 8 * k -: 8];
      for (int i = 7; i >= 0; i--) bit_cycle(cur[i], tag);
    end
    end_frame(tag);
  endtask

  // RD_DATA frame clocked for nb bits after the turnaround; exp holds the MISO stream.
  task automatic rd_data(input logic [23:0] exp, input int nb, input string tag);
    push_zeros(3);
    for (int j = 0; j < nb; j++) exp_q.push_back(exp[23 - j]);
    bit_cycle(1'b1, tag);
    bit_cycle(1'b1, tag);
    bit_cycle(1'($urandom_range(0, 1)), tag);
    for (int j = 0; j < nb; j++) bit_cycle(1'($urandom_range(0, 1)), tag);
    end_frame(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs = '{
      '{addr: 8'h3C, data: 8'hA5, exp: 8'hA5},
      '{addr: 8'h00, data: 8'h5A, exp: 8'h5A},
      '{addr: 8'hFF, data: 8'hC3, exp: 8'hC3},
      '{addr: 8'h80, data: 8'h01, exp: 8'h01},
      '{addr: 8'h7F, data: 8'hFE, exp: 8'hFE},
      '{addr: 8'hC8, data: 8'h80, exp: 8'h80}
    };

    rst_a = 1'b1;
    rst_b = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso_a", {7'b0, ifa.MISO}, 8'h00);
    check("reset_miso_b", {7'b0, ifb.MISO}, 8'h00);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // Single-word write/read through every table row, read back after all writes.
    for (int r = 0; r < 6; r++) begin
      wr_addr(vecs[r].addr);
      wr_data({vecs[r].data, 16'h0}, 1, $sformatf("tbl_wr%0d", r));
    end
    for (int r = 0; r < 6; r++) begin
      rd_addr(vecs[r].addr);
      rd_data({vecs[r].exp, 16'h0}, 8, $sformatf("tbl_rd%0d", r));
    end

    // Abort mid-word: RAM and wptr untouched, next frame decodes from E0.
    wr_addr(8'h40);
    wr_data({8'h77, 16'h0}, 1, "abort_setup");
    wr_addr(8'h40);
    push_zeros(7);
    bit_cycle(1'b0, "abort");
    bit_cycle(1'b1, "abort");
    repeat (5) bit_cycle(1'b1, "abort");
    end_frame("abort");
    rd_addr(8'h40);
    rd_data({8'h77, 16'h0}, 8, "abort_ram");
    wr_data({8'h5A, 16'h0}, 1, "abort_wptr_wr");
    rd_addr(8'h40);
    rd_data({8'h5A, 16'h0}, 8, "abort_wptr_rd");

`ifdef SPI_RAM_BURST_EN
    wr_addr(8'hFE);
    wr_data({8'h11, 8'h22, 8'h33}, 3, "burst_wr");
    wr_data({8'h5E, 16'h0}, 1, "burst_wptr_wr");
    rd_addr(8'hFE);
    rd_data({8'h11, 8'h22, 8'h33}, 24, "burst_rd");
    rd_addr(8'h01);
    rd_data({8'h5E, 16'h0}, 8, "burst_wptr_rd");
`else
    wr_addr(8'h51);
    wr_data({8'hAA, 16'h0}, 1, "single_setup");
    wr_addr(8'h50);
    wr_data({8'h11, 8'h22, 8'h00}, 2, "single_wr2");
    rd_addr(8'h50);
    rd_data({8'h11, 8'h00, 8'h00}, 16, "single_rd2");
    rd_data({8'hAA, 16'h0}, 8, "single_rptr_once");
    wr_data({8'h66, 16'h0}, 1, "single_wptr_wr");
    rd_addr(8'h51);
    rd_data({8'h66, 16'h0}, 8, "single_wptr_rd");
`endif

    // Depth 200: out-of-range load ignored, non-power-of-2 wrap, reset mid-read.
    sel = 1'b1;
    wr_addr(8'h10);
    wr_data({8'hE1, 16'h0}, 1, "b_wr10");
    wr_addr(8'hC8);
    wr_data({8'h2B, 16'h0}, 1, "b_wr_oor");
    wr_addr(8'hC7);
    wr_data({8'h9D, 16'h0}, 1, "b_wr_last");
    wr_data({8'h44, 16'h0}, 1, "b_wr_wrap");
    rd_addr(8'h11);
    rd_data({8'h2B, 16'h0}, 8, "b_rd_oor");
    rd_addr(8'hC7);
    rd_data({8'h9D, 16'h0}, 8, "b_rd_last");
    rd_data({8'h44, 16'h0}, 8, "b_rd_wrap");

    rd_addr(8'h10);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    bit_cycle(1'b1, "rst_e0");
    bit_cycle(1'b1, "rst_e1");
    bit_cycle(1'b0, "rst_e2");
    bit_cycle(1'b0, "rst_e3");
    bit_cycle(1'b0, "rst_e4");
    rst_b = 1'b1;
    push_zeros(2);
    bit_cycle(1'b0, "rst_e5");
    bit_cycle(1'b1, "rst_e6");
    rst_b = 1'b0;
    push_zeros(8);
    for (int i = 0; i < 8; i++) bit_cycle(1'b1, "rst_wait_ss");
    end_frame("rst_wait_ss");
    rd_data({8'h44, 16'h0}, 8, "rst_rptr0");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
